computer: RTL and testbench



---
 rtl/arch_defs_pkg.sv | 49 ++++
 rtl/alu.sv | 34 +++
 rtl/cpu.sv | 158 +++++++++++++++
 rtl/ram.sv | 24 ++
 rtl/rom.sv | 19 +
 rtl/computer.sv | 72 +++++++
 tb/tb_computer.sv | 209 ++++++++++++++++++++
 7 files changed

// File: rtl/arch_defs_pkg.sv
// Shared architecture definitions for the 8-bit accumulator computer:
// widths, opcodes, FSM states and memory-map constants.
package arch_defs_pkg;

    localparam int DATA_WIDTH = 8;
    localparam int ADDR_WIDTH = 16;

    localparam int ROM_SIZE = 4096;
    localparam int RAM_SIZE = 256;
    localparam logic [ADDR_WIDTH-1:0] ROM_BASE = 16'h0000;
    localparam logic [ADDR_WIDTH-1:0] RAM_BASE = 16'h8000;

    typedef enum logic [7:0] {
        OP_NOP  = 8'h00,
        OP_HLT  = 8'h01,
        OP_LDIA = 8'h10,
        OP_LDIB = 8'h11,
        OP_LDIC = 8'h12,
        OP_ADDB = 8'h20,
        OP_ADDC = 8'h21,
        OP_SUBB = 8'h28,
        OP_SUBC = 8'h29,
        OP_ANAB = 8'h30,
        OP_ANAC = 8'h31,
        OP_ORAB = 8'h38,
        OP_ORAC = 8'h39,
        OP_XRAB = 8'h40,
        OP_XRAC = 8'h41,
        OP_LDA  = 8'h50,
        OP_STA  = 8'h51,
        OP_JMP  = 8'h60,
        OP_OUT  = 8'h70
    } opcode_t;

    typedef enum logic [3:0] {
        S_F0, S_F1, S_EX,
        S_O0, S_O1, S_O3,
        S_M0, S_M1, S_HALT
    } state_t;

    function automatic logic is_imm(input logic [7:0] op);
        return op == OP_LDIA || op == OP_LDIB || op == OP_LDIC;
    endfunction

    function automatic logic is_abs(input logic [7:0] op);
        return op == OP_LDA || op == OP_STA || op == OP_JMP;
    endfunction

endpackage

// File: rtl/alu.sv
// Combinational ALU: op + A + r -> result, Z, N, C.
// hit is high when op is an ALU opcode (flags/result valid).
module alu
    import arch_defs_pkg::*;
(
    input  logic [7:0]            op,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] r,
    output logic [DATA_WIDTH-1:0] res,
    output logic                  z,
    output logic                  n,
    output logic                  c,
    output logic                  hit
);

    always_comb begin
        res = a;
        c   = 1'b0;
        hit = 1'b1;
        case (op)
            OP_ADDB, OP_ADDC: {c, res} = {1'b0, a} + {1'b0, r};
            // carry out of A + ~r + 1 is the "no borrow" flag
            OP_SUBB, OP_SUBC: {c, res} = {1'b0, a} + {1'b0, ~r} + 9'd1;
            OP_ANAB, OP_ANAC: res = a & r;
            OP_ORAB, OP_ORAC: res = a | r;
            OP_XRAB, OP_XRAC: res = a ^ r;
            default:          hit = 1'b0;
        endcase
    end

    assign z = (res == '0);
    assign n = res[DATA_WIDTH-1];

endmodule

// File: rtl/cpu.sv
// Multi-cycle accumulator CPU: FSM, A/B/C, Z/N/C flags, output latch.
// Ports: clk, reset, bus (addr/rdata/wdata/we), reg/flag taps, port, status.
module cpu
    import arch_defs_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] rdata,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [DATA_WIDTH-1:0] wdata,
    output logic                  we,
    output logic [DATA_WIDTH-1:0] a_out,
    output logic [DATA_WIDTH-1:0] b_out,
    output logic [DATA_WIDTH-1:0] c_out,
    output logic                  flag_zero_o,
    output logic                  flag_negative_o,
    output logic                  flag_carry_o,
    output logic [DATA_WIDTH-1:0] port,
    output logic                  instr_complete,
    output logic                  halt
);

    state_t state, state_n;
    logic [ADDR_WIDTH-1:0] pc;
    logic [7:0] ir, lo, hi;
    logic [DATA_WIDTH-1:0] a, b, c;
    logic fz, fn, fc;

    logic [DATA_WIDTH-1:0] alu_res;
    logic alu_z, alu_n, alu_c, alu_hit;

    alu u_alu (
        .op (ir),
        .a  (a),
        .r  (ir[0] ? c : b),
        .res(alu_res),
        .z  (alu_z),
        .n  (alu_n),
        .c  (alu_c),
        .hit(alu_hit)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_F0;
        else       state <= state_n;
    end

    always_comb begin
        state_n        = state;
        addr           = pc;
        we             = 1'b0;
        instr_complete = 1'b0;
        unique case (state)
            S_F0: state_n = S_F1;
            S_F1: state_n = (is_imm(rdata) || is_abs(rdata)) ? S_O0 : S_EX;
            S_EX: begin
                instr_complete = 1'b1;
                state_n = (ir == OP_HLT) ? S_HALT : S_F0;
            end
            S_O0: state_n = S_O1;
            S_O1: begin
                if (is_imm(ir)) begin
                    instr_complete = 1'b1;
                    state_n = S_F0;
                end else begin
                    // issue the high-byte read while the low byte lands
                    addr = pc + 16'd1;
                    state_n = S_O3;
                end
            end
            S_O3: begin
                if (ir == OP_JMP) begin
                    instr_complete = 1'b1;
                    state_n = S_F0;
                end else begin
                    state_n = S_M0;
                end
            end
            S_M0: begin
                addr = {hi, lo};
                state_n = S_M1;
            end
            S_M1: begin
                addr = {hi, lo};
                we = (ir == OP_STA);
                instr_complete = 1'b1;
                state_n = S_F0;
            end
            S_HALT: state_n = S_HALT;
            default: state_n = S_F0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc   <= '0;
            ir   <= '0;
            lo   <= '0;
            hi   <= '0;
            a    <= '0;
            b    <= '0;
            c    <= '0;
            fz   <= 1'b0;
            fn   <= 1'b0;
            fc   <= 1'b0;
            port <= '0;
            halt <= 1'b0;
        end else begin
            unique case (state)
                S_F1: begin
                    ir <= rdata;
                    pc <= pc + 16'd1;
                end
                S_EX: begin
                    unique case (1'b1)
                        alu_hit: begin
                            a  <= alu_res;
                            fz <= alu_z;
                            fn <= alu_n;
                            fc <= alu_c;
                        end
                        ir == OP_OUT: port <= a;
                        ir == OP_HLT: halt <= 1'b1;
                        default: ;
                    endcase
                end
                S_O1: begin
                    pc <= pc + 16'd1;
                    unique case (1'b1)
                        ir == OP_LDIA: a <= rdata;
                        ir == OP_LDIB: b <= rdata;
                        ir == OP_LDIC: c <= rdata;
                        default:       lo <= rdata;
                    endcase
                end
                S_O3: begin
                    if (ir == OP_JMP) begin
                        pc <= {rdata, lo};
                    end else begin
                        hi <= rdata;
                        pc <= pc + 16'd1;
                    end
                end
                S_M1: if (ir == OP_LDA) a <= rdata;
                default: ;
            endcase
        end
    end

    assign wdata           = a;
    assign a_out           = a;
    assign b_out           = b;
    assign c_out           = c;
    assign flag_zero_o     = fz;
    assign flag_negative_o = fn;
    assign flag_carry_o    = fc;

endmodule

// File: rtl/ram.sv
// Data RAM, 256 B, synchronous read (1-cycle latency), sync write.
// Ports: clk, we, addr[7:0], wdata[7:0], data[7:0].
module ram
    import arch_defs_pkg::*;
(
    input  logic                  clk,
    input  logic                  we,
    input  logic [7:0]            addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] data
);

    logic [DATA_WIDTH-1:0] mem [RAM_SIZE];

    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
        data <= mem[addr];
    end

    task automatic init_sim_ram();
        for (int i = 0; i < RAM_SIZE; i++) mem[i] <= '0;
    endtask

endmodule

// File: rtl/rom.sv
// Program ROM, 4 KB, synchronous read (1-cycle latency).
// Ports: clk, addr[11:0], data[7:0].
module rom
    import arch_defs_pkg::*;
(
    input  logic                  clk,
    input  logic [11:0]           addr,
    output logic [DATA_WIDTH-1:0] data
);

    logic [DATA_WIDTH-1:0] mem [ROM_SIZE];

    always_ff @(posedge clk) data <= mem[addr];

    task automatic init_sim_rom();
        for (int i = 0; i < ROM_SIZE; i++) mem[i] = '0;
    endtask

endmodule

// File: rtl/computer.sv
// Top level: CPU + 4 KB ROM @0000 + 256 B RAM @8000 + output port.
// Ports: clk, reset (async, high), output_port_1, uart_rx/uart_tx (idle).
module computer
    import arch_defs_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    output logic [DATA_WIDTH-1:0] output_port_1,
    input  logic                  uart_rx,
    output logic                  uart_tx
);

    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] rdata, wdata, rom_data, ram_data;
    logic we, rom_hit, ram_hit, rom_q, ram_q;
    logic cpu_instr_complete, cpu_halt;

    assign rom_hit = (addr[15:12] == ROM_BASE[15:12]);
    assign ram_hit = (addr[15:8] == RAM_BASE[15:8]);

    // reads return a cycle later, so steer them with the registered region
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rom_q <= 1'b0;
            ram_q <= 1'b0;
        end else begin
            rom_q <= rom_hit;
            ram_q <= ram_hit;
        end
    end

    assign rdata = rom_q ? rom_data :
                   ram_q ? ram_data : '0;

    cpu u_cpu (
        .clk            (clk),
        .reset          (reset),
        .rdata          (rdata),
        .addr           (addr),
        .wdata          (wdata),
        .we             (we),
        .a_out          (),
        .b_out          (),
        .c_out          (),
        .flag_zero_o    (),
        .flag_negative_o(),
        .flag_carry_o   (),
        .port           (output_port_1),
        .instr_complete (cpu_instr_complete),
        .halt           (cpu_halt)
    );

    rom u_rom (
        .clk (clk),
        .addr(addr[11:0]),
        .data(rom_data)
    );

    ram u_ram (
        .clk  (clk),
        .we   (we && ram_hit),
        .addr (addr[7:0]),
        .wdata(wdata),
        .data (ram_data)
    );

    logic [2:0] unused_sig;
    assign unused_sig = {uart_rx, cpu_instr_complete, cpu_halt};

    assign uart_tx = 1'b1;

endmodule

// File: tb/tb_computer.sv
// Directed-program bench for computer: loads ROM images, steps
// instructions via cpu_instr_complete and checks architectural state.
module tb_computer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       uart_rx = 1'b1;
    logic       uart_tx;
    logic [7:0] port;

    int n_chk = 0;
    int n_fail = 0;

    computer dut (
        .clk          (clk),
        .reset        (reset),
        .output_port_1(port),
        .uart_rx      (uart_rx),
        .uart_tx      (uart_tx)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic load(input int base, input logic [7:0] b[$]);
        foreach (b[i]) dut.u_rom.mem[base + i] = b[i];
    endtask

    // run one instruction; leaves time #1 after its commit edge
    task automatic step(input string tag, input int exp_cyc);
        int n = 0;
        bit done = 1'b0;
        while (!done && n < 50) begin
            @(negedge clk);
            n++;
            done = dut.cpu_instr_complete;
        end
        if (done) begin
            @(posedge clk);
            #1;
        end
        chk({tag, ".cyc"}, done ? n : 999, exp_cyc);
    endtask

    logic [7:0] p1[$] = {
        8'h10, 8'hE1, 8'h12, 8'hFE, 8'h21, 8'h31,
        8'h12, 8'h00, 8'h31,
        8'h10, 8'hAA, 8'h12, 8'h55, 8'h31,
        8'h10, 8'h80, 8'h12, 8'h7F, 8'h31,
        8'h11, 8'h42, 8'h10, 8'h3C, 8'h12, 8'hC3, 8'h31,
        8'h01
    };

    logic [7:0] p2a[$] = {
        8'h10, 8'h5A, 8'h51, 8'h10, 8'h80, 8'h11, 8'h42, 8'h28,
        8'h10, 8'h00, 8'h50, 8'h10, 8'h80, 8'h70,
        8'h60, 8'h20, 8'h00, 8'h10, 8'hFF
    };

    logic [7:0] p2b[$] = {8'h20, 8'h01};

    initial begin
        int pulses;

        reset = 1'b1;
        dut.u_rom.init_sim_rom();
        load(0, p1);
        repeat (2) @(posedge clk);
        #1;
        chk("rst.a", dut.u_cpu.a_out, 8'h00);
        chk("rst.b", dut.u_cpu.b_out, 8'h00);
        chk("rst.c", dut.u_cpu.c_out, 8'h00);
        chk("rst.flags", {dut.u_cpu.flag_zero_o, dut.u_cpu.flag_negative_o,
                          dut.u_cpu.flag_carry_o}, 3'b000);
        chk("rst.port", port, 8'h00);
        chk("rst.halt", dut.cpu_halt, 1'b0);
        chk("rst.tx", uart_tx, 1'b1);
        reset = 1'b0;

        step("ldi_a", 4);
        chk("ldi_a.a", dut.u_cpu.a_out, 8'hE1);
        step("ldi_c", 4);
        step("add_c", 3);
        chk("add.a", dut.u_cpu.a_out, 8'hDF);
        chk("add.cf", dut.u_cpu.flag_carry_o, 1'b1);
        step("ana1", 3);
        chk("ana1.a", dut.u_cpu.a_out, 8'hDE);
        chk("ana1.znc", {dut.u_cpu.flag_zero_o, dut.u_cpu.flag_negative_o,
                         dut.u_cpu.flag_carry_o}, 3'b010);

        step("ldi_c0", 4);
        step("ana2", 3);
        chk("ana2.a", dut.u_cpu.a_out, 8'h00);
        chk("ana2.zn", {dut.u_cpu.flag_zero_o, dut.u_cpu.flag_negative_o},
            2'b10);

        step("ldi_aa", 4);
        step("ldi_55", 4);
        step("ana3", 3);
        chk("ana3.a", dut.u_cpu.a_out, 8'h00);
        chk("ana3.z", dut.u_cpu.flag_zero_o, 1'b1);

        step("ldi_80", 4);
        step("ldi_7f", 4);
        step("ana4", 3);
        chk("ana4.a", dut.u_cpu.a_out, 8'h00);
        chk("ana4.n", dut.u_cpu.flag_negative_o, 1'b0);

        step("ldi_b", 4);
        step("ldi_3c", 4);
        step("ldi_c3", 4);
        step("ana5", 3);
        chk("ana5.a", dut.u_cpu.a_out, 8'h00);
        chk("ana5.b", dut.u_cpu.b_out, 8'h42);
        chk("ana5.c", dut.u_cpu.c_out, 8'hC3);
        chk("ana5.z", dut.u_cpu.flag_zero_o, 1'b1);

        step("hlt", 3);
        chk("hlt.halt", dut.cpu_halt, 1'b1);
        pulses = 0;
        repeat (10) begin
            @(negedge clk);
            if (dut.cpu_instr_complete) pulses++;
        end
        chk("frz.pulses", pulses, 0);
        chk("frz.halt", dut.cpu_halt, 1'b1);
        chk("frz.a", dut.u_cpu.a_out, 8'h00);
        chk("frz.b", dut.u_cpu.b_out, 8'h42);
        chk("frz.c", dut.u_cpu.c_out, 8'hC3);

        reset = 1'b1;
        dut.u_rom.init_sim_rom();
        load(0, p2a);
        load(32, p2b);
        @(posedge clk);
        #1;
        chk("rst2.halt", dut.cpu_halt, 1'b0);
        chk("rst2.b", dut.u_cpu.b_out, 8'h00);
        reset = 1'b0;

        step("ldi_5a", 4);
        step("sta", 7);
        chk("sta.mem", dut.u_ram.mem[8'h10], 8'h5A);
        step("ldi_b42", 4);
        step("sub_b", 3);
        chk("sub.a", dut.u_cpu.a_out, 8'h18);
        chk("sub.znc", {dut.u_cpu.flag_zero_o, dut.u_cpu.flag_negative_o,
                        dut.u_cpu.flag_carry_o}, 3'b001);
        step("ldi_00", 4);
        chk("ldi_00.a", dut.u_cpu.a_out, 8'h00);
        chk("ldi_00.cf", dut.u_cpu.flag_carry_o, 1'b1);
        step("lda", 7);
        chk("lda.a", dut.u_cpu.a_out, 8'h5A);
        step("out", 3);
        chk("out.port", port, 8'h5A);
        step("jmp", 5);
        step("add_b", 3);
        chk("add_b.a", dut.u_cpu.a_out, 8'h9C);
        chk("add_b.znc", {dut.u_cpu.flag_zero_o, dut.u_cpu.flag_negative_o,
                          dut.u_cpu.flag_carry_o}, 3'b010);
        step("hlt2", 3);
        chk("hlt2.halt", dut.cpu_halt, 1'b1);
        chk("hlt2.tx", uart_tx, 1'b1);

        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        step("r3.ldi", 4);
        step("r3.sta", 7);
        step("r3.ldib", 4);
        step("r3.sub", 3);
        step("r3.ldi0", 4);
        chk("r3.b", dut.u_cpu.b_out, 8'h42);
        chk("r3.cf", dut.u_cpu.flag_carry_o, 1'b1);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("midrst.a", dut.u_cpu.a_out, 8'h00);
        chk("midrst.b", dut.u_cpu.b_out, 8'h00);
        chk("midrst.cf", dut.u_cpu.flag_carry_o, 1'b0);
        chk("midrst.port", port, 8'h00);
        chk("midrst.cmpl", dut.cpu_instr_complete, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        step("r4.ldi", 4);
        chk("r4.a", dut.u_cpu.a_out, 8'h5A);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
